// File: rtl/data_sram_responder_if.sv
// Core-to-responder data SRAM port: request fields driven by the core, read data returned one cycle later.
// Handshake: an access is accepted on every rising edge where data_sram_en=1; there is no ready/stall.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-lane RAM plus SCRATCH/LED/TIMER/WCOUNT MMIO window, 1-cycle read-before-write data.
// Optional feature macro: DATA_SRAM_TIMER_EN builds the free-running TIMER register at offset 0x8.
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    data_sram_responder_if.slave        sram,
    output logic [15:0]                 led
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic [31:0]           r_scratch;
    logic [15:0]           r_led;
    logic [31:0]           r_wcount;

    logic                  w_access;
    logic                  w_mmio_hit;
    logic                  w_wr;
    logic                  w_ram_wr;
    logic                  w_mmio_wr;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [13:0]           w_off;
    logic [31:0]           w_ram_rd;
    logic [31:0]           w_mmio_rd;
    logic [31:0]           w_timer_val;
    logic [31:0]           w_led_merged;
    logic                  w_unused;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = we[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // Reset in an access cycle drops the access, so every write is gated here.
    assign w_access     = sram.data_sram_en && !reset;
    assign w_mmio_hit   = (sram.data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign w_wr         = (sram.data_sram_we != 4'b0000);
    assign w_ram_wr     = w_access && w_wr && !w_mmio_hit;
    assign w_mmio_wr    = w_access && w_wr && w_mmio_hit;
    assign w_idx        = sram.data_sram_addr[ADDR_WIDTH+1:2];
    assign w_off        = sram.data_sram_addr[15:2];
    assign w_ram_rd     = r_mem[w_idx];
    assign w_led_merged = lane_merge({16'h0000, r_led}, sram.data_sram_wdata, sram.data_sram_we);
    assign w_unused     = ^sram.data_sram_addr[1:0];

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram.data_sram_we[i]) begin
                    r_mem[w_idx][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_mmio_rd = 32'h0000_0000;
        case (w_off)
            14'h0000: w_mmio_rd = r_scratch;
            14'h0001: w_mmio_rd = {16'h0000, r_led};
            14'h0002: w_mmio_rd = w_timer_val;
            14'h0003: w_mmio_rd = r_wcount;
            default:  w_mmio_rd = 32'h0000_0000;
        endcase
    end

    // rdata captures the pre-write word, so writes also return the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0000_0000;
        end else if (sram.data_sram_en) begin
            r_rdata <= w_mmio_hit ? w_mmio_rd : w_ram_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scratch <= 32'h0000_0000;
            r_led     <= 16'h0000;
        end else if (w_mmio_wr) begin
            if (w_off == 14'h0000) begin
                r_scratch <= lane_merge(r_scratch, sram.data_sram_wdata, sram.data_sram_we);
            end
            if (w_off == 14'h0001) begin
                r_led <= w_led_merged[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcount <= 32'h0000_0000;
        end else if (w_ram_wr && (r_wcount != 32'hFFFF_FFFF)) begin
            r_wcount <= r_wcount + 32'd1;
        end
    end

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] r_timer;

    // A write in the same cycle replaces the increment; counting resumes next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 32'h0000_0000;
        end else if (w_mmio_wr && (w_off == 14'h0002)) begin
            r_timer <= lane_merge(r_timer, sram.data_sram_wdata, sram.data_sram_we);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer_val = r_timer;
`else
    assign w_timer_val = 32'h0000_0000;
`endif

    assign sram.data_sram_rdata = r_rdata;
    assign led                  = r_led;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed accesses, a spec-level reference model compared every cycle,
// and literal expectations at the key points of each scenario.
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] led;

    data_sram_responder_if bus ();

    data_sram_responder dut (
        .clk   (clk),
        .reset (reset),
        .sram  (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: RAM as a sparse map of known words, timer as base value + elapsed cycles.
    logic [31:0] m_ram [int];
    logic [31:0] m_scratch = 32'h0;
    logic [15:0] m_led     = 16'h0;
    logic [31:0] m_wcount  = 32'h0;
    logic [31:0] m_tbase   = 32'h0;
    longint      m_cycle   = 0;
    longint      m_tcycle  = 0;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_known = 1'b0;
    bit          model_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] we);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] m_timer();
        return m_tbase + 32'(m_cycle - m_tcycle);
    endfunction

    always @(posedge clk) begin
        logic [31:0] a;
        logic [31:0] rd;
        logic [31:0] tmp;
        logic [31:0] off;
        int          idx;
        a = bus.data_sram_addr;
        if (reset) begin
            exp_rdata = 32'h0;
            exp_known = 1'b1;
            m_scratch = 32'h0;
            m_led     = 16'h0;
            m_wcount  = 32'h0;
            m_tbase   = 32'h0;
            m_tcycle  = m_cycle + 1;
        end else if (bus.data_sram_en) begin
            if ((a >> 16) == 32'h0000_BFAF) begin
                off = (a & 32'h0000_FFFF) & ~32'h3;
                case (off)
                    32'h0: rd = m_scratch;
                    32'h4: rd = {16'h0, m_led};
`ifdef DATA_SRAM_TIMER_EN
                    32'h8: rd = m_timer();
`endif
                    32'hC: rd = m_wcount;
                    default: rd = 32'h0;
                endcase
                exp_known = 1'b1;
                if (bus.data_sram_we != 4'h0) begin
                    case (off)
                        32'h0: m_scratch = merge(m_scratch, bus.data_sram_wdata, bus.data_sram_we);
                        32'h4: begin
                            tmp   = merge({16'h0, m_led}, bus.data_sram_wdata, bus.data_sram_we);
                            m_led = tmp[15:0];
                        end
`ifdef DATA_SRAM_TIMER_EN
                        32'h8: begin
                            m_tbase  = merge(m_timer(), bus.data_sram_wdata, bus.data_sram_we);
                            m_tcycle = m_cycle + 1;
                        end
`endif
                        default: ;
                    endcase
                end
            end else begin
                idx = int'((a >> 2) % 4096);
                exp_known = m_ram.exists(idx);
                rd = exp_known ? m_ram[idx] : 32'h0;
                if (bus.data_sram_we != 4'h0) begin
                    if (m_ram.exists(idx)) m_ram[idx] = merge(m_ram[idx], bus.data_sram_wdata, bus.data_sram_we);
                    else if (bus.data_sram_we == 4'hF) m_ram[idx] = bus.data_sram_wdata;
                    if (m_wcount != 32'hFFFF_FFFF) m_wcount = m_wcount + 1;
                end
            end
            exp_rdata = rd;
        end
        m_cycle++;
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            if (exp_known) check("model_rdata", bus.data_sram_rdata, exp_rdata);
            check("model_led", {16'h0, led}, {16'h0, m_led});
        end
    end

    task automatic acc(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        rd = bus.data_sram_rdata;
        bus.data_sram_en = 1'b0;
        bus.data_sram_we = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] rd;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        reset = 1'b0;

        acc(4'h0, 32'h0000_0010, 32'h0, rd);
        acc(4'h0, 32'hBFAF_0004, 32'h0, rd);
        check("led_read_after_reset", rd, 32'h0);
        check("led_pin_after_reset", {16'h0, led}, 32'h0);

        acc(4'hF, 32'h0000_0040, 32'h1122_3344, rd);
        acc(4'b0101, 32'h0000_0040, 32'hAABB_CCDD, rd);
        check("read_before_write", rd, 32'h1122_3344);
        acc(4'h0, 32'h0000_0040, 32'h0, rd);
        check("lane_merge", rd, 32'h11BB_33DD);
        acc(4'h0, 32'h0000_4040, 32'h0, rd);
        check("ram_alias", rd, 32'h11BB_33DD);

        acc(4'hF, 32'hBFAF_0004, 32'h0000_A5A5, rd);
        check("led_pin", {16'h0, led}, 32'h0000_A5A5);
        acc(4'hF, 32'hBFAF_0004, 32'hFFFF_1234, rd);
        acc(4'h0, 32'hBFAF_0004, 32'h0, rd);
        check("led_upper_zero", rd, 32'h0000_1234);
        acc(4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF, rd);
        acc(4'h0, 32'hBFAF_0000, 32'h0, rd);
        check("scratch_rw", rd, 32'hFFFF_FFFF);
        acc(4'b0010, 32'hBFAF_0000, 32'h0, rd);
        acc(4'h0, 32'hBFAF_0000, 32'h0, rd);
        check("scratch_lane", rd, 32'hFFFF_00FF);
        acc(4'hF, 32'hBFAF_0010, 32'h0000_0123, rd);
        acc(4'h0, 32'hBFAF_0010, 32'h0, rd);
        check("unmapped_zero", rd, 32'h0);

        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc(4'hF, 32'h0000_0100, 32'h0000_0001, rd);
        acc(4'hF, 32'h0000_0104, 32'h0000_0002, rd);
        acc(4'hF, 32'h0000_0108, 32'h0000_0003, rd);
        acc(4'hF, 32'hBFAF_0000, 32'h0000_0055, rd);
        acc(4'hF, 32'hBFAF_0004, 32'h0000_0066, rd);
        acc(4'h0, 32'h0000_0100, 32'h0, rd);
        check("ram_readback", rd, 32'h0000_0001);
        acc(4'h0, 32'hBFAF_000C, 32'h0, rd);
        check("wcount", rd, 32'd3);
        acc(4'hF, 32'hBFAF_000C, 32'h0000_0099, rd);
        acc(4'h0, 32'hBFAF_000C, 32'h0, rd);
        check("wcount_ro", rd, 32'd3);

        acc(4'hF, 32'hBFAF_0008, 32'h0000_0100, rd);
        repeat (4) @(negedge clk);
        acc(4'h0, 32'hBFAF_0008, 32'h0, rd);
`ifdef DATA_SRAM_TIMER_EN
        check("timer_n_plus_5", rd, 32'h0000_0104);
`else
        check("timer_absent", rd, 32'h0);
`endif

        acc(4'hF, 32'h0000_0080, 32'h1234_5678, rd);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_we    = 4'hF;
        bus.data_sram_addr  = 32'h0000_0080;
        bus.data_sram_wdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_drops_rdata", bus.data_sram_rdata, 32'h0);
        check("reset_clears_led", {16'h0, led}, 32'h0);
        bus.data_sram_en = 1'b0;
        bus.data_sram_we = 4'h0;
        reset = 1'b0;
        acc(4'h0, 32'h0000_0080, 32'h0, rd);
        check("reset_drops_write", rd, 32'h1234_5678);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
